// File: rtl/onehot_decoder_buf_if.sv
// rtl/onehot_decoder_buf_if.sv - code-in / one-hot-out handshake bundle
interface onehot_decoder_buf_if #(
    parameter int N_IN = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN-1:0]      in_code;
    logic                 in_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [(1<<N_IN)-1:0] out_onehot;

    // Producer/consumer side (drives codes, accepts one-hot vectors)
    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    // Decoder side
    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_onehot
    );
endinterface

// File: rtl/onehot_decoder_buf.sv
// rtl/onehot_decoder_buf.sv - registered 3-to-8 one-hot decoder with output FIFO and transfer counter
module onehot_decoder_buf #(
    parameter int N_IN  = 3,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    onehot_decoder_buf_if.slave bus,
    output logic [CNT_W-1:0]  xfer_cnt
);
    localparam int         W    = 1 << N_IN;
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             init_q;
    logic [CNT_W-1:0] cnt_q;

    logic             push, pop;
    logic [W-1:0]     entry_d;

    // in_ready depends only on registered state; init_q keeps it low until the first edge after reset
    assign bus.in_ready   = init_q && (count_q != FULL);
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_onehot = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign xfer_cnt       = cnt_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Decode at push time; a disabled transfer stores an all-zero entry
    always_comb begin
        entry_d = '0;
        if (bus.in_en) begin
            entry_d = W'(1) << bus.in_code;
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, occupancy and saturating pop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            init_q  <= 1'b1;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= entry_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end
endmodule
